// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, feeding the deserializer stage.
// Sends the top len bits of a latched word; len of 1 or 2 is dropped.
module serializer #(
    parameter int WIDTH = 16,
    parameter int MOD_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [MOD_W-1:0] data_mod_i,
    input  logic             data_val_i,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             busy_o
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(WIDTH);
    localparam logic [MOD_W:0] MIN_LEN  = (MOD_W+1)'(3);
    localparam logic [MOD_W:0] ONE      = (MOD_W+1)'(1);

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [MOD_W:0]   cnt_q;
    logic [MOD_W:0]   cnt_d;
    logic             bit_q;
    logic             bit_d;
    logic             val_q;
    logic             val_d;
    logic             busy_q;

    logic [MOD_W:0]   len;
    logic             accept;
    logic             last_bit;

    // Effective length: a zero mod selects the whole word.
    always_comb begin
        len = {1'b0, data_mod_i};
        if (data_mod_i == '0) begin
            len = FULL_LEN;
        end
    end

    // Accept only in IDLE and only words long enough to be sent.
    always_comb begin
        accept   = (state_q == IDLE) && data_val_i && (len >= MIN_LEN);
        last_bit = (cnt_q == ONE);
    end

    // Next-state logic; cnt_q holds bits still to show, current included.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        val_d   = val_q;
        unique case (state_q)
            IDLE: begin
                bit_d = 1'b0;
                val_d = 1'b0;
                if (accept) begin
                    state_d = SEND;
                    shift_d = data_i;
                    cnt_d   = len;
                    bit_d   = data_i[WIDTH-1];
                    val_d   = 1'b1;
                end
            end
            SEND: begin
                if (last_bit) begin
                    state_d = IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
                    bit_d   = 1'b0;
                    val_d   = 1'b0;
                end else begin
                    shift_d = shift_q << 1;
                    cnt_d   = cnt_q - ONE;
                    bit_d   = shift_q[WIDTH-2];
                    val_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
                bit_d   = 1'b0;
                val_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any word in flight.
    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= 1'b0;
            val_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            val_q   <= val_d;
            busy_q  <= val_d;
        end
    end

    assign ser_data_o     = bit_q;
    assign ser_data_val_o = val_q;
    assign busy_o         = busy_q;

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Parallel-to-serial converter that sits directly upstream of the deserializer stage.
- Accepts a WIDTH-bit word plus a valid-bit count and emits the selected bits one per clock, MSB first.
- Its output pair (ser_data_o, ser_data_val_o) connects directly to the deserializer's data_i / data_val_i.
- Gives the team a closed serial loop for bring-up and loopback testing.

Parameters:
- WIDTH, 16, parallel word width; must be a power of two ≥ 4.
- MOD_W, $clog2(WIDTH), width of data_mod_i.

Ports:
- clk_i  input  1  single clock; all logic on rising edge.
- srst_i  input  1  synchronous reset, active-low (0 = reset, sampled on clk_i rising edge).
- data_i  input  WIDTH  parallel word; bit WIDTH-1 is transmitted first.
- data_mod_i  input  MOD_W  number of bits to send, taken from the top of data_i; 0 means all WIDTH bits.
- data_val_i  input  1  word/mod valid; accepted only when busy_o = 0.
- ser_data_o  output  1  serial bit.
- ser_data_val_o  output  1  ser_data_o is valid this cycle.
- busy_o  output  1  transmission in progress; input ignored.

Behaviour:
- Reset (srst_i = 0 at an edge):
  - ser_data_o = 0, ser_data_val_o = 0, busy_o = 0.
  - Shift register and bit counter cleared.
  - Reset wins over any other event in the same cycle.
  - Reset mid-transmission aborts the word immediately; no further valid bits; the word is not resumed.
- States:
  - IDLE: busy_o = 0, ser_data_val_o = 0, ser_data_o = 0.
  - SEND: busy_o = 1, ser_data_val_o = 1.
- Effective length: len = (data_mod_i == 0) ? WIDTH : data_mod_i.
- Accept rule: at edge N with state IDLE and data_val_i = 1:
  - len ≥ 3: latch data_i and len, go to SEND.
  - len = 1 or 2: word is dropped; block stays IDLE; no output, busy_o stays 0.
- Latency: the first bit (data_i[WIDTH-1]) is on ser_data_o in the cycle after edge N.
  - Bit k (k = 0..len-1) appears in cycle N+1+k and equals data_i[WIDTH-1-k].
- Completion: after the edge ending cycle N+len, return to IDLE.
  - ser_data_val_o = 0 and busy_o = 0 in cycle N+len+1.
  - A new word may be accepted at that edge; first bit in cycle N+len+2.
  - Minimum gap between words is exactly one idle cycle.
- busy_o == ser_data_val_o at all times. Both are registered outputs with no combinational path from inputs.
- data_val_i, data_i and data_mod_i are don't-care while busy_o = 1. A word presented while busy_o = 1 is lost, not queued.
- data_i bits below the selected top len bits are ignored.
- Counter width is MOD_W+1 so len = WIDTH does not wrap.

Test Plan:
- Reset check: hold srst_i = 0 for 2 cycles with data_val_i = 1 -> ser_data_val_o = 0, busy_o = 0, ser_data_o = 0 throughout.
- Full word: data_i = 16'hA5C3, data_mod_i = 0, one-cycle data_val_i -> 16 valid cycles starting the next cycle, bits 1010_0101_1100_0011 in order, busy_o high for exactly those 16 cycles.
- Partial/illegal mod:
  - data_i = 16'hF000, mod = 5 -> 5 valid cycles with bits 1,1,1,1,0.
  - mod = 3 -> 3 cycles of 1.
  - mod = 1 and mod = 2 -> no ser_data_val_o pulse, busy_o stays 0.
- Busy ignore and back-to-back: send 16'hFFFF (mod 0) and assert 16'h0000 during transmission -> exactly 16 ones, no extra bits. Then hold data_val_i = 1 with 16'h8001, mod 0 -> one idle cycle, then 1, 14 zeros, 1.
- Reset mid-operation: start 16'hFFFF and drive srst_i = 0 at the 6th bit -> ser_data_val_o = 0 from the next cycle, block returns to IDLE, next word transmits normally.
- Loopback: connect to the deserializer and send 16'h1234 (mod 0) -> deserializer outputs deser_data_o = 16'h1234 with a single deser_data_val_o pulse.
